// File: rtl/sprite_pkg.sv
// Shared sprite constants, coordinate types and the hit-test helper.
package sprite_pkg;

   localparam int unsigned H_ACTIVE    = 640;
   localparam int unsigned V_ACTIVE    = 480;
   localparam int unsigned COORD_W     = 10;
   localparam int unsigned COORD_EXT_W = 11;

   typedef logic [COORD_W-1:0]     coord_t;
   typedef logic [COORD_EXT_W-1:0] coord_ext_t;

   // True when the draw coordinate lies in the ext_w x ext_h box at (pos_x,pos_y).
   // Differences are taken in 11 bits so a sprite near the right/bottom edge
   // clips instead of wrapping back to column/row 0.
   function automatic logic sprite_inside(input coord_t     draw_x,
                                          input coord_t     draw_y,
                                          input coord_t     pos_x,
                                          input coord_t     pos_y,
                                          input coord_ext_t ext_w,
                                          input coord_ext_t ext_h);
      coord_ext_t dx;
      coord_ext_t dy;
      dx = {1'b0, draw_x} - {1'b0, pos_x};
      dy = {1'b0, draw_y} - {1'b0, pos_y};
      return (draw_x >= pos_x) && (draw_y >= pos_y) && (dx < ext_w) && (dy < ext_h);
   endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// Frame-rate bookkeeping: latches position/flip once per video frame and
// steps the animation frame every FRAME_DIV enabled frame_start pulses.
module sprite_anim_ctr
   import sprite_pkg::*;
#(
   parameter int unsigned NUM_FRAMES = 4,
   parameter int unsigned FRAME_DIV  = 8,
   parameter int unsigned FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
)(
   input  logic               vga_clk,
   input  logic               reset,
   input  logic               frame_start,
   input  logic               anim_en,
   input  coord_t             sprite_x,
   input  coord_t             sprite_y,
   input  logic               flip_h,
   output coord_t             pos_x,
   output coord_t             pos_y,
   output logic               flip_r,
   output logic [FRAME_W-1:0] anim_frame
);

   localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   logic [DIV_W-1:0] div_cnt;

   // Position and flip only change at frame_start so a frame never tears.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         pos_x  <= '0;
         pos_y  <= '0;
         flip_r <= 1'b0;
      end else if (frame_start) begin
         pos_x  <= sprite_x;
         pos_y  <= sprite_y;
         flip_r <= flip_h;
      end
   end

   // Divider and animation frame counter, wrapping at FRAME_DIV / NUM_FRAMES.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         div_cnt    <= '0;
         anim_frame <= '0;
      end else if (frame_start && anim_en) begin
         if (div_cnt == DIV_W'(FRAME_DIV - 1)) begin
            div_cnt <= '0;
            if (anim_frame == FRAME_W'(NUM_FRAMES - 1)) begin
               anim_frame <= '0;
            end else begin
               anim_frame <= anim_frame + FRAME_W'(1);
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/sprite_animator.sv
// Sprite engine: scaled/flipped/animated sprite placement with transparency.
// Coordinate -> registered ROM address -> ROM data -> registered hit/index.
module sprite_animator
   import sprite_pkg::*;
#(
   parameter int unsigned SPR_W           = 16,
   parameter int unsigned SPR_H           = 16,
   parameter int unsigned NUM_FRAMES      = 4,
   parameter int unsigned FRAME_DIV       = 8,
   parameter int unsigned SCALE_LOG2      = 0,
   parameter int unsigned PIX_BITS        = 4,
   parameter int unsigned TRANSPARENT_IDX = 0,
   parameter int unsigned ADDR_W          = $clog2(SPR_W * SPR_H * NUM_FRAMES),
   localparam int unsigned FRAME_W        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
)(
   input  logic                vga_clk,
   input  logic                reset,
   input  logic [9:0]          DrawX,
   input  logic [9:0]          DrawY,
   input  logic                blank,
   input  logic                frame_start,
   input  logic [9:0]          sprite_x,
   input  logic [9:0]          sprite_y,
   input  logic                flip_h,
   input  logic                anim_en,
   output logic [ADDR_W-1:0]   rom_address,
   input  logic [PIX_BITS-1:0] rom_q,
   output logic                pix_hit,
   output logic [PIX_BITS-1:0] pix_index,
   output logic [FRAME_W-1:0]  anim_frame
);

   localparam int unsigned COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int unsigned ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

   coord_t pos_x;
   coord_t pos_y;
   logic   flip_r;

   sprite_anim_ctr #(
      .NUM_FRAMES (NUM_FRAMES),
      .FRAME_DIV  (FRAME_DIV),
      .FRAME_W    (FRAME_W)
   ) u_anim_ctr (
      .vga_clk     (vga_clk),
      .reset       (reset),
      .frame_start (frame_start),
      .anim_en     (anim_en),
      .sprite_x    (sprite_x),
      .sprite_y    (sprite_y),
      .flip_h      (flip_h),
      .pos_x       (pos_x),
      .pos_y       (pos_y),
      .flip_r      (flip_r),
      .anim_frame  (anim_frame)
   );

   coord_ext_t        dx_c;
   coord_ext_t        dy_c;
   logic              inside_c;
   logic [COL_W-1:0]  col_raw_c;
   logic [COL_W-1:0]  col_c;
   logic [ROW_W-1:0]  row_c;
   logic [ADDR_W-1:0] addr_c;

   // Hit test and frame-indexed ROM address for the current draw coordinate.
   always_comb begin
      dx_c      = {1'b0, DrawX} - {1'b0, pos_x};
      dy_c      = {1'b0, DrawY} - {1'b0, pos_y};
      inside_c  = sprite_inside(DrawX, DrawY, pos_x, pos_y,
                                COORD_EXT_W'(SPR_W << SCALE_LOG2),
                                COORD_EXT_W'(SPR_H << SCALE_LOG2));
      col_raw_c = COL_W'(dx_c >> SCALE_LOG2);
      col_c     = flip_r ? (COL_W'(SPR_W - 1) - col_raw_c) : col_raw_c;
      row_c     = ROW_W'(dy_c >> SCALE_LOG2);
      addr_c    = '0;
      if (inside_c) begin
         addr_c = (ADDR_W'(anim_frame) * ADDR_W'(SPR_W * SPR_H))
                + (ADDR_W'(row_c) * ADDR_W'(SPR_W))
                + ADDR_W'(col_c);
      end
   end

   logic vld_d1;
   logic vld_d2;

   // Address stage plus a valid bit (inside & active video) riding alongside.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         rom_address <= '0;
         vld_d1      <= 1'b0;
      end else begin
         rom_address <= addr_c;
         vld_d1      <= inside_c & blank;
      end
   end

   // Valid bit delayed to line up with rom_q.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         vld_d2 <= 1'b0;
      end else begin
         vld_d2 <= vld_d1;
      end
   end

   // Output stage: transparent or invalid pixels report no hit and index 0.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         pix_hit   <= 1'b0;
         pix_index <= '0;
      end else if (vld_d2 && (rom_q != PIX_BITS'(TRANSPARENT_IDX))) begin
         pix_hit   <= 1'b1;
         pix_index <= rom_q;
      end else begin
         pix_hit   <= 1'b0;
         pix_index <= '0;
      end
   end

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: directed literal checks plus randomized traffic
// compared every cycle against a plain-arithmetic model.
module tb_sprite_animator;

   localparam int SPR_W = 16;
   localparam int SPR_H = 16;
   localparam int NF    = 4;
   localparam int FD    = 2;
   localparam int SC    = 1;
   localparam int PB    = 4;
   localparam int TI    = 0;
   localparam int AW    = 10;

   logic          vga_clk = 1'b0;
   logic          reset;
   logic [9:0]    DrawX, DrawY;
   logic          blank, frame_start, flip_h, anim_en;
   logic [9:0]    sprite_x, sprite_y;
   logic [AW-1:0] rom_address;
   logic [PB-1:0] rom_q;
   logic          pix_hit;
   logic [PB-1:0] pix_index;
   logic [1:0]    anim_frame;

   logic [PB-1:0] rom_mem [0:(1<<AW)-1];

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   sprite_animator #(
      .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NF), .FRAME_DIV(FD),
      .SCALE_LOG2(SC), .PIX_BITS(PB), .TRANSPARENT_IDX(TI), .ADDR_W(AW)
   ) dut (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
      .blank(blank), .frame_start(frame_start), .sprite_x(sprite_x),
      .sprite_y(sprite_y), .flip_h(flip_h), .anim_en(anim_en),
      .rom_address(rom_address), .rom_q(rom_q), .pix_hit(pix_hit),
      .pix_index(pix_index), .anim_frame(anim_frame)
   );

   always #5 vga_clk = ~vga_clk;

   // Synchronous sprite ROM.
   always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state.
   int m_px = 0, m_py = 0, m_flip = 0, m_div = 0, m_frame = 0, m_addr = 0;
   int p0_hit = 0, p0_idx = 0, p1_hit = 0, p1_idx = 0, o_hit = 0, o_idx = 0;

   // Model: each sampled coordinate yields an address now and a pixel two clocks later.
   always @(posedge vga_clk or posedge reset) begin
      int dx, dy, col, row, a, d;
      bit in_spr;
      if (reset) begin
         m_px = 0; m_py = 0; m_flip = 0; m_div = 0; m_frame = 0; m_addr = 0;
         p0_hit = 0; p0_idx = 0; p1_hit = 0; p1_idx = 0; o_hit = 0; o_idx = 0;
      end else begin
         dx = int'(DrawX) - m_px;
         dy = int'(DrawY) - m_py;
         in_spr = (dx >= 0) && (dy >= 0) && (dx < SPR_W * (1 << SC)) && (dy < SPR_H * (1 << SC));
         col = dx / (1 << SC);
         if (m_flip != 0) col = SPR_W - 1 - col;
         row = dy / (1 << SC);
         a = in_spr ? (m_frame * SPR_W * SPR_H + row * SPR_W + col) : 0;
         d = int'(rom_mem[a]);
         o_hit = p1_hit; o_idx = p1_idx;
         p1_hit = p0_hit; p1_idx = p0_idx;
         p0_hit = (in_spr && blank && d != TI) ? 1 : 0;
         p0_idx = (p0_hit != 0) ? d : 0;
         m_addr = a;
         if (frame_start) begin
            m_px = int'(sprite_x); m_py = int'(sprite_y); m_flip = int'(flip_h);
            if (anim_en) begin
               m_div = m_div + 1;
               if (m_div >= FD) begin
                  m_div = 0;
                  m_frame = (m_frame + 1) % NF;
               end
            end
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge vga_clk) begin
      if (chk_en && !reset) begin
         chk("rom_address", 32'(rom_address), 32'(m_addr));
         chk("pix_hit",     32'(pix_hit),     32'(o_hit));
         chk("pix_index",   32'(pix_index),   32'(o_idx));
         chk("anim_frame",  32'(anim_frame),  32'(m_frame));
      end
   end

   task automatic pulse();
      frame_start = 1'b1;
      @(negedge vga_clk);
      frame_start = 1'b0;
      @(negedge vga_clk);
   endtask

   task automatic probe(input int x, input int y, input bit b,
                        output logic [31:0] addr, output logic [31:0] hit,
                        output logic [31:0] idx);
      DrawX = 10'(x); DrawY = 10'(y); blank = b;
      @(negedge vga_clk);
      addr = 32'(rom_address);
      blank = 1'b0;
      @(negedge vga_clk);
      @(negedge vga_clk);
      hit = 32'(pix_hit);
      idx = 32'(pix_index);
   endtask

   initial begin
      logic [31:0] a, h, ix;
      int seq [9];
      int x;
      seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

      for (int i = 0; i < (1 << AW); i++)
         rom_mem[i] = ($urandom_range(0, 3) == 0) ? '0 : PB'($urandom_range(1, 15));
      rom_mem[18] = 4'd5;
      rom_mem[29] = 4'd0;
      for (int c = 0; c < 5; c++) rom_mem[512 + c] = PB'(c + 1);

      reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0; frame_start = 1'b0;
      sprite_x = '0; sprite_y = '0; flip_h = 1'b0; anim_en = 1'b0;
      repeat (3) @(negedge vga_clk);
      chk("reset_addr",  32'(rom_address), 0);
      chk("reset_hit",   32'(pix_hit),     0);
      chk("reset_index", 32'(pix_index),   0);
      chk("reset_frame", 32'(anim_frame),  0);
      reset = 1'b0;
      chk_en = 1'b1;
      @(negedge vga_clk);

      // Scaled position, flip, transparency, blank and extent.
      sprite_x = 10'd100; sprite_y = 10'd50; pulse();
      probe(105, 53, 1'b1, a, h, ix);
      chk("scaled_addr", a, 18); chk("scaled_hit", h, 1); chk("scaled_idx", ix, 5);
      flip_h = 1'b1; pulse();
      probe(105, 53, 1'b1, a, h, ix);
      chk("flip_addr", a, 29); chk("transp_hit", h, 0); chk("transp_idx", ix, 0);
      flip_h = 1'b0; pulse();
      probe(105, 53, 1'b0, a, h, ix);
      chk("blank_addr", a, 18); chk("blank_hit", h, 0);
      probe(131, 53, 1'b1, a, h, ix);
      chk("last_col_addr", a, 31);
      probe(132, 53, 1'b1, a, h, ix);
      chk("outside_addr", a, 0); chk("outside_hit", h, 0);

      // Animation sequence with FRAME_DIV=2 and wrap.
      anim_en = 1'b1;
      for (int k = 0; k < 9; k++) begin
         chk("anim_seq", 32'(anim_frame), 32'(seq[k]));
         pulse();
      end
      repeat (3) pulse();
      chk("anim_frame2", 32'(anim_frame), 2);
      anim_en = 1'b0;
      repeat (3) pulse();
      chk("anim_hold", 32'(anim_frame), 2);
      probe(100, 50, 1'b1, a, h, ix);
      chk("frame2_addr", a, 512); chk("frame2_hit", h, 1); chk("frame2_idx", ix, 1);

      // Right-edge clipping without wrap.
      sprite_x = 10'd630; pulse();
      for (int px = 630; px < 640; px++) begin
         probe(px, 50, 1'b1, a, h, ix);
         chk("clip_addr", a, 32'(512 + (px - 630) / 2));
         chk("clip_hit", h, 1);
         chk("clip_idx", ix, 32'((px - 630) / 2 + 1));
      end
      for (int px = 0; px < 6; px++) begin
         probe(px, 50, 1'b1, a, h, ix);
         chk("nowrap_hit", h, 0);
      end

      // Mid-frame request changes are ignored until frame_start.
      sprite_x = 10'd200;
      probe(632, 50, 1'b1, a, h, ix);
      chk("midframe_hit", h, 1); chk("midframe_idx", ix, 2);
      probe(200, 50, 1'b1, a, h, ix);
      chk("midframe_new_hit", h, 0);

      // Async reset in the middle of a hit run.
      DrawX = 10'd630; DrawY = 10'd50; blank = 1'b1;
      repeat (3) @(negedge vga_clk);
      chk("prereset_hit", 32'(pix_hit), 1);
      @(posedge vga_clk);
      #2 reset = 1'b1;
      #1;
      chk("async_hit",   32'(pix_hit),    0);
      chk("async_frame", 32'(anim_frame), 0);
      chk("async_addr",  32'(rom_address), 0);
      @(negedge vga_clk);
      reset = 1'b0; blank = 1'b0;
      @(negedge vga_clk);
      probe(3, 1, 1'b1, a, h, ix);
      chk("post_reset_addr", a, 1);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 15) == 0) begin
            sprite_x = 10'($urandom_range(0, 639));
            sprite_y = 10'($urandom_range(0, 479));
            flip_h   = 1'($urandom_range(0, 1));
            anim_en  = 1'($urandom_range(0, 1));
         end
         frame_start = ($urandom_range(0, 39) == 0);
         blank = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 9) == 0) begin
            DrawX = 10'($urandom_range(0, 1023));
            DrawY = 10'($urandom_range(0, 1023));
         end else begin
            x = m_px + int'($urandom_range(0, 40)) - 4;
            DrawX = 10'(x);
            x = m_py + int'($urandom_range(0, 40)) - 4;
            DrawY = 10'(x);
         end
         @(negedge vga_clk);
      end
      frame_start = 1'b0; blank = 1'b0;
      repeat (4) @(negedge vga_clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
